bus_arbiter_rr: RTL and testbench

//  Parametrised arbiter for the shared system bus. It collects the per-master DMA request lines
//  (I cache, D cache, DMA engines) and issues a one-hot grant to a single master. It drives
//  BUS_req towards the memory slave and counts BUS_ready beats. It supports fixed-priority or

---
 rtl/bus_arbiter_rr.sv | 165 ++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Shared system bus arbiter: fixed-priority or round-robin selection among
// N_CH masters, one-hot registered grant, per-tenure beat limit for fairness
// and a watchdog that revokes a grant whose slave never answers.
module bus_arbiter_rr #(
    parameter int N_CH      = 8,
    parameter int MODE      = 1,
    parameter int MAX_BEATS = 4,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [N_CH-1:0]         DMA,
    input  logic                    BUS_ready,
    output logic [N_CH-1:0]         grant,
    output logic                    BUS_req,
    output logic [$clog2(N_CH)-1:0] owner,
    output logic                    busy,
    output logic                    bus_err
);

    localparam int OW = $clog2(N_CH);

    // Beat counter cap: the limit itself when enabled, otherwise all-ones so
    // an unlimited tenure still never wraps.
    localparam logic [CNT_W-1:0] BEAT_LIM = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BEAT_CAP = (MAX_BEATS != 0) ? BEAT_LIM : CNT_MAX;
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
    localparam bit               LIM_EN   = (MAX_BEATS != 0);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

    logic [OW-1:0]     base;
    logic [OW-1:0]     off;
    logic [OW:0]       win_sum;
    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     ptr_nxt;
    logic [2*N_CH-1:0] rot;

    logic              own_req;
    logic              others;
    logic [CNT_W-1:0]  beat_next;
    logic              wd_fire;
    logic              lim_hit;

    // Saturating increment: counters stop at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    // Winner search: rotate the request vector so the search base sits at
    // bit 0, take the lowest set bit, then rotate the offset back.
    always_comb begin
        base = (MODE == 0) ? '0 : rr_ptr_q;
        rot  = {DMA, DMA} >> base;
        off  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = OW'(i);
        end
        win_sum = {1'b0, base} + {1'b0, off};
        if (win_sum >= (OW+1)'(N_CH)) win_sum = win_sum - (OW+1)'(N_CH);
        win_idx = win_sum[OW-1:0];
        ptr_nxt = (win_idx == OW'(N_CH - 1)) ? '0 : win_idx + OW'(1);
    end

    assign own_req   = |(grant_q & DMA);
    assign others    = |(DMA & ~grant_q);
    assign beat_next = sat_inc(beat_cnt_q, BEAT_CAP);
    assign wd_fire   = WD_EN && !BUS_ready && (wd_cnt_q == WD_LAST);
    assign lim_hit   = LIM_EN && BUS_ready && (beat_next == BEAT_LIM) && others;

    // Next-state logic: arbitration in IDLE, tenure tracking and release
    // (drop beats watchdog beats beat limit) in GRANT, one turnaround in GAP.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        bus_err    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                beat_cnt_d = '0;
                wd_cnt_d   = '0;
                if (|DMA) begin
                    state_d  = S_GRANT;
                    grant_d  = N_CH'(1) << win_idx;
                    owner_d  = win_idx;
                    rr_ptr_d = ptr_nxt;
                end
            end
            S_GRANT: begin
                if (BUS_ready) begin
                    beat_cnt_d = beat_next;
                    wd_cnt_d   = '0;
                end else begin
                    wd_cnt_d = sat_inc(wd_cnt_q, CNT_MAX);
                end
                if (!own_req) begin
                    state_d = S_GAP;
                    grant_d = '0;
                end else if (wd_fire) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    bus_err = 1'b1;
                end else if (lim_hit) begin
                    state_d = S_GAP;
                    grant_d = '0;
                end
            end
            S_GAP: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
                wd_cnt_d   = '0;
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
                wd_cnt_d   = '0;
            end
        endcase
    end

    // State and tenure registers; reset drops any grant immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = (state_q == S_GRANT);
    assign BUS_req = busy && own_req;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a round-robin instance and a fixed-priority
// instance share the same stimulus; a tenure-level model predicts both.
module tb_bus_arbiter_rr;

    localparam int NC = 8;
    localparam int MB = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] dma = 8'h00;
    logic       rdy = 1'b0;

    logic [7:0] grant0, grant1;
    logic       busreq0, busreq1, busy0, busy1, err0, err1;
    logic [2:0] owner0, owner1;

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 = nobody), turnaround flag, next-search pointer,
    // beats this tenure and cycles since last beat. Index 0 = RR, 1 = fixed.
    int m_own   [2] = '{-1, -1};
    int m_ptr   [2] = '{0, 0};
    int m_beats [2] = '{0, 0};
    int m_stall [2] = '{0, 0};
    bit m_gap   [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    bus_arbiter_rr #(.N_CH(NC), .MODE(1), .MAX_BEATS(MB), .TIMEOUT(TO), .CNT_W(8)) dut_rr (
        .clk(clk), .clr(clr), .DMA(dma), .BUS_ready(rdy),
        .grant(grant0), .BUS_req(busreq0), .owner(owner0), .busy(busy0), .bus_err(err0)
    );

    bus_arbiter_rr #(.N_CH(NC), .MODE(0), .MAX_BEATS(MB), .TIMEOUT(TO), .CNT_W(8)) dut_fp (
        .clk(clk), .clr(clr), .DMA(dma), .BUS_ready(rdy),
        .grant(grant1), .BUS_req(busreq1), .owner(owner1), .busy(busy1), .bus_err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int d, input logic [7:0] req);
        int start;
        start = (d == 0) ? m_ptr[d] : 0;
        for (int k = 0; k < NC; k++) begin
            int c;
            c = (start + k) % NC;
            if (((req >> c) & 8'h01) != 8'h00) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1; m_ptr[d] = 0; m_beats[d] = 0; m_stall[d] = 0; m_gap[d] = 1'b0;
        end
    endfunction

    // Advance one clock using the inputs that the coming rising edge will see.
    function automatic void model_step(input int d);
        logic [7:0] mine;
        bit own_req, others, rel;
        if (m_gap[d]) begin
            m_gap[d] = 1'b0;
            return;
        end
        if (m_own[d] < 0) begin
            int w;
            w = pick(d, dma);
            if (w >= 0) begin
                m_own[d] = w; m_ptr[d] = (w + 1) % NC; m_beats[d] = 0; m_stall[d] = 0;
            end
            return;
        end
        mine    = 8'h01 << m_own[d];
        own_req = (dma & mine) != 8'h00;
        others  = (dma & ~mine) != 8'h00;
        rel     = 1'b0;
        if (!own_req) rel = 1'b1;
        else if (!rdy && m_stall[d] == TO - 1) rel = 1'b1;
        else if (rdy) begin
            if (m_beats[d] < MB) m_beats[d]++;
            if (m_beats[d] == MB && others) rel = 1'b1;
        end
        if (rdy) m_stall[d] = 0;
        else if (m_stall[d] < 255) m_stall[d]++;
        if (rel) begin
            m_own[d] = -1; m_gap[d] = 1'b1;
        end
    endfunction

    task automatic cmp(input int d, input logic [7:0] g, input logic r, input logic [2:0] o,
                       input logic b, input logic e);
        int         own;
        bit         eb, er, ee;
        logic [7:0] eg;
        own = m_own[d];
        eb  = own >= 0;
        eg  = 8'h00;
        er  = 1'b0;
        if (eb) begin
            eg = 8'h01 << own;
            er = ((dma >> own) & 8'h01) != 8'h00;
        end
        ee = er && !rdy && (m_stall[d] == TO - 1);
        chk($sformatf("dut%0d_grant", d), 32'(g), 32'(eg));
        chk($sformatf("dut%0d_busy", d), 32'(b), 32'(eb));
        chk($sformatf("dut%0d_bus_req", d), 32'(r), 32'(er));
        chk($sformatf("dut%0d_bus_err", d), 32'(e), 32'(ee));
        if (eb) chk($sformatf("dut%0d_owner", d), 32'(o), 32'(own));
    endtask

    // Compare both DUTs on every falling edge, then advance the model.
    initial begin
        forever begin
            @(negedge clk or posedge clr);
            if (clr) begin
                model_reset();
                if (clk == 1'b1) continue;
            end
            if (clk == 1'b0) begin
                cmp(0, grant0, busreq0, owner0, busy0, err0);
                cmp(1, grant1, busreq1, owner1, busy1, err1);
                if (!clr) begin
                    model_step(0);
                    model_step(1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int         ntn, bts, gp, n;
        logic [7:0] prev;
        logic [7:0] seq [4];

        // T1: reset with all masters requesting
        dma = 8'hFF;
        tick(); tick(); peek();
        chk("t1_grant_in_reset", 32'(grant0), 32'h0);
        chk("t1_busy_in_reset", 32'(busy0), 32'h0);
        chk("t1_bus_req_in_reset", 32'(busreq0), 32'h0);
        chk("t1_bus_err_in_reset", 32'(err0), 32'h0);
        chk("t1_owner_in_reset", 32'(owner0), 32'h0);
        clr = 1'b0;
        tick();
        chk("t1_first_grant", 32'(grant0), 32'h01);
        chk("t1_first_busy", 32'(busy0), 32'h1);
        chk("t1_first_owner", 32'(owner0), 32'h0);
        dma = 8'h00;
        tick(); tick(); tick();

        // T3: round robin over 0x85 with slave ready every cycle
        clr = 1'b1; #1; clr = 1'b0;
        dma = 8'h85; rdy = 1'b1;
        ntn = 0; bts = 0; gp = 0; prev = 8'h00;
        for (int i = 0; i < 4; i++) seq[i] = 8'h00;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick(); peek();
            if (grant0 != 8'h00 && prev == 8'h00) begin
                if (ntn > 0) chk("t3_idle_gap", 32'(gp), 32'd2);
                if (ntn < 4) seq[ntn] = grant0;
                ntn++;
                bts = 0;
            end
            if (grant0 == 8'h00 && prev != 8'h00) begin
                chk("t3_tenure_beats", 32'(bts), 32'd4);
                gp = 0;
            end
            if (grant0 != 8'h00 && busreq0 && rdy) bts++;
            if (grant0 == 8'h00) gp++;
            prev = grant0;
        end
        chk("t3_tenures", 32'(ntn), 32'd4);
        chk("t3_seq0", 32'(seq[0]), 32'h01);
        chk("t3_seq1", 32'(seq[1]), 32'h04);
        chk("t3_seq2", 32'(seq[2]), 32'h80);
        chk("t3_seq3", 32'(seq[3]), 32'h01);
        dma = 8'h00; rdy = 1'b0;
        tick(); tick(); tick();

        // T2: fixed priority, 0x0A, owner releases after 2 beats
        dma = 8'h0A;
        for (int t = 0; t < 2; t++) begin
            n = 0;
            while (grant1 == 8'h00 && n < 10) begin
                tick();
                n++;
            end
            chk("t2_grant", 32'(grant1), 32'h02);
            rdy = 1'b1;
            peek();
            chk("t2_bus_req", 32'(busreq1), 32'h1);
            tick();
            chk("t2_grant_hold1", 32'(grant1), 32'h02);
            tick();
            dma = 8'h08; rdy = 1'b0;
            chk("t2_grant_hold2", 32'(grant1), 32'h02);
            tick();
            chk("t2_released", 32'(grant1), 32'h00);
            dma = 8'h0A;
        end
        dma = 8'h00;
        tick(); tick(); tick(); tick();

        // T4: single requester is never forced off by the beat limit
        dma = 8'h10; rdy = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            peek();
            chk("t4_hold_rr", 32'(grant0), 32'h10);
            chk("t4_hold_fp", 32'(grant1), 32'h10);
            tick();
        end
        dma = 8'h11;
        peek();
        chk("t4_still_held", 32'(grant0), 32'h10);
        tick();
        chk("t4_saturated_release", 32'(grant0), 32'h00);
        dma = 8'h00; rdy = 1'b0;
        tick(); tick(); tick();

        // T5: watchdog revoke on a silent slave, then re-grant
        dma = 8'h04;
        tick();
        chk("t5_grant", 32'(grant0), 32'h04);
        for (int c = 1; c <= 64; c++) begin
            peek();
            chk("t5_bus_err", 32'(err0), 32'(c == 64));
            tick();
        end
        chk("t5_revoked", 32'(grant0), 32'h00);
        chk("t5_err_cleared", 32'(err0), 32'h0);
        tick(); tick();
        chk("t5_regrant", 32'(grant0), 32'h04);

        // T6: asynchronous reset in the middle of a tenure
        #2;
        clr = 1'b1;
        #1;
        chk("t6_grant_async", 32'(grant0), 32'h00);
        chk("t6_bus_req_async", 32'(busreq0), 32'h0);
        chk("t6_busy_async", 32'(busy0), 32'h0);
        clr = 1'b0;
        dma = 8'hFF;
        tick();
        chk("t6_ptr_reset", 32'(grant0), 32'h01);
        dma = 8'h00;
        tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
